// File: rtl/conv_input_pkg.sv
// Shared definitions for the convolution input stage: sequencer state
// encoding, the pointer step applied at row switch and default widths.
package conv_input_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } seq_state_e;

    // Pointer step the sub-input FIFOs apply at a row-final read; also the window width.
    localparam int unsigned SWITCH_STEP     = 3;
    localparam int unsigned INPUT_COL_WIDTH = 6;
    localparam int unsigned COUNT_WIDTH     = 6;

endpackage

// File: rtl/conv_window_pos_cnt.sv
// Column/row position counters for the window read sequencer.
// The column counter wraps at size-2; the row counter advances on the wrap.
// Row-final and frame-final flags describe the current position, and the
// caller qualifies them with its own read-issue strobe.
module conv_window_pos_cnt #(
    parameter int unsigned COL_WIDTH = 6,
    parameter int unsigned ROW_WIDTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_advance,
    input  logic [COL_WIDTH-1:0] i_size,
    input  logic [ROW_WIDTH-1:0] i_rows,
    output logic [COL_WIDTH-1:0] o_col,
    output logic                 o_row_final,
    output logic                 o_frame_final
);

    logic [COL_WIDTH-1:0] col_q, col_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;

    // Position flags and next-count computation.
    always_comb begin
        o_row_final   = (col_q == (i_size - COL_WIDTH'(2)));
        o_frame_final = o_row_final && (row_q == (i_rows - ROW_WIDTH'(1)));
        col_d = col_q;
        row_d = row_q;
        if (i_clear) begin
            col_d = '0;
            row_d = '0;
        end else if (i_advance) begin
            if (o_row_final) begin
                col_d = '0;
                row_d = row_q + ROW_WIDTH'(1);
            end else begin
                col_d = col_q + COL_WIDTH'(1);
            end
        end
    end

    // Counter registers, synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign o_col = col_q;

endmodule

// File: rtl/conv_window_read_seq.sv
// Read sequencer for the convolution input stage sub-input FIFOs.
// Drives a common read enable and column index to NUM_FIFOS FIFOs, tracks
// the window held in the FIFO output registers and hands it to the PE array
// under valid/ready.
// Optional build macro SEQ_PERF_CNT_EN adds saturating starve/stall counters.
module conv_window_read_seq #(
    parameter int unsigned NUM_FIFOS       = 3,
    parameter int unsigned READ_PORTS      = conv_input_pkg::SWITCH_STEP,
    parameter int unsigned INPUT_COL_WIDTH = conv_input_pkg::INPUT_COL_WIDTH,
    parameter int unsigned ROW_WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH     = conv_input_pkg::COUNT_WIDTH
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [INPUT_COL_WIDTH-1:0]       i_output_size,
    input  logic [ROW_WIDTH-1:0]             i_output_rows,
    input  logic [NUM_FIFOS*COUNT_WIDTH-1:0] i_element_count,
    input  logic [NUM_FIFOS-1:0]             i_read_data_valid,
    input  logic                             i_pe_ready,
    output logic                             o_renable,
    output logic [INPUT_COL_WIDTH-1:0]       o_valid_read_count,
    output logic                             o_window_valid,
    output logic                             o_row_done,
    output logic                             o_frame_done,
    output logic                             o_busy,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]                      o_starve_cycles,
    output logic [31:0]                      o_stall_cycles,
`endif
    output logic                             o_cfg_err
);

    import conv_input_pkg::*;

    seq_state_e state_q, state_d;

    logic [INPUT_COL_WIDTH-1:0] size_q, size_d;
    logic [ROW_WIDTH-1:0]       rows_q, rows_d;

    // rd_pend_q: a read was issued last cycle, data lands in the FIFO output
    // registers now. win_hold_q: a presented window is still waiting for ready.
    logic rd_pend_q, rd_pend_d;
    logic win_hold_q, win_hold_d;
    logic tag_q, tag_d;

    logic [NUM_FIFOS-1:0]       fifo_ok;
    logic                       counts_ok;
    logic                       cfg_ok;
    logic                       start_accept;
    logic                       issue;
    logic                       win_now;
    logic                       accept;
    logic                       pos_clear;
    logic                       pos_row_final;
    logic                       pos_frame_final;
    logic [INPUT_COL_WIDTH-1:0] pos_col;

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_cnt
        assign fifo_ok[g] = (i_element_count[g*COUNT_WIDTH +: COUNT_WIDTH] >= COUNT_WIDTH'(READ_PORTS));
    end

    assign counts_ok    = &fifo_ok;
    assign cfg_ok       = (i_output_size >= INPUT_COL_WIDTH'(READ_PORTS)) && (i_output_rows != '0);
    assign start_accept = (state_q == IDLE) && i_start && cfg_ok;

    // A window whose read returned with any FIFO data-valid low is dropped here.
    assign win_now = win_hold_q | (rd_pend_q & (&i_read_data_valid));
    assign accept  = win_now && i_pe_ready;
    assign issue   = (state_q == STREAM) && counts_ok && (!win_now || i_pe_ready);

    assign o_renable          = issue;
    assign o_valid_read_count = pos_col;
    assign o_window_valid     = win_now;
    assign o_busy             = (state_q != IDLE);

    conv_window_pos_cnt #(
        .COL_WIDTH (INPUT_COL_WIDTH),
        .ROW_WIDTH (ROW_WIDTH)
    ) u_pos_cnt (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_clear       (pos_clear),
        .i_advance     (issue),
        .i_size        (size_q),
        .i_rows        (rows_q),
        .o_col         (pos_col),
        .o_row_final   (pos_row_final),
        .o_frame_final (pos_frame_final)
    );

    // Next-state, configuration latch and handshake pulses.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        rows_d       = rows_q;
        pos_clear    = 1'b0;
        o_cfg_err    = 1'b0;
        o_row_done   = accept && tag_q;
        o_frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (cfg_ok) begin
                        state_d   = STREAM;
                        size_d    = i_output_size;
                        rows_d    = i_output_rows;
                        pos_clear = 1'b1;
                    end else begin
                        o_cfg_err = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (issue && pos_frame_final) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The only tagged window left in DRAIN is the frame's last one.
                if (accept && tag_q) begin
                    o_frame_done = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window tracking next values; issue overlapping acceptance keeps the window valid.
    always_comb begin
        rd_pend_d  = issue;
        win_hold_d = win_now && !i_pe_ready;
        tag_d      = issue ? pos_row_final : tag_q;
    end

    // Sequencer state registers, synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            size_q     <= '0;
            rows_q     <= '0;
            rd_pend_q  <= 1'b0;
            win_hold_q <= 1'b0;
            tag_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            rows_q     <= rows_d;
            rd_pend_q  <= rd_pend_d;
            win_hold_q <= win_hold_d;
            tag_q      <= tag_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] starve_q, starve_d;
    logic [31:0] stall_q, stall_d;

    // Saturating starve/stall counters, cleared when a frame starts.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (start_accept) begin
            starve_d = '0;
            stall_d  = '0;
        end else begin
            if ((state_q == STREAM) && !counts_ok && (starve_q != '1)) begin
                starve_d = starve_q + 32'd1;
            end
            if (win_now && !i_pe_ready && (stall_q != '1)) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            starve_q <= '0;
            stall_q  <= '0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign o_starve_cycles = starve_q;
    assign o_stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_read_seq.sv
// Testbench for conv_window_read_seq: frame-level behavioural model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_conv_window_read_seq;

    localparam int NF   = 3;
    localparam int CW   = 6;
    localparam int COLW = 6;
    localparam int RW   = 8;

    logic               i_clock = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_start = 1'b0;
    logic [COLW-1:0]    i_output_size = '0;
    logic [RW-1:0]      i_output_rows = '0;
    logic [NF*CW-1:0]   i_element_count = '0;
    logic [NF-1:0]      i_read_data_valid = '1;
    logic               i_pe_ready = 1'b1;
    logic               o_renable;
    logic [COLW-1:0]    o_valid_read_count;
    logic               o_window_valid;
    logic               o_row_done;
    logic               o_frame_done;
    logic               o_busy;
    logic               o_cfg_err;

    always #5 i_clock = ~i_clock;

    conv_window_read_seq #(
        .NUM_FIFOS       (NF),
        .READ_PORTS      (3),
        .INPUT_COL_WIDTH (COLW),
        .ROW_WIDTH       (RW),
        .COUNT_WIDTH     (CW)
    ) dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_output_size      (i_output_size),
        .i_output_rows      (i_output_rows),
        .i_element_count    (i_element_count),
        .i_read_data_valid  (i_read_data_valid),
        .i_pe_ready         (i_pe_ready),
        .o_renable          (o_renable),
        .o_valid_read_count (o_valid_read_count),
        .o_window_valid     (o_window_valid),
        .o_row_done         (o_row_done),
        .o_frame_done       (o_frame_done),
        .o_busy             (o_busy),
        .o_cfg_err          (o_cfg_err)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Frame model: windows are numbered 0..total-1 in issue order.
    int m_busy    = 0;
    int m_issued  = 0;
    int m_total   = 0;
    int m_per_row = 1;
    int m_wv      = 0;
    int m_widx    = 0;

    int ren_cols[$];
    int row_done_n   = 0;
    int frame_done_n = 0;
    int cfg_err_n    = 0;
    int cyc          = 0;
    int first_ren    = 0;
    int last_ren     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_cols(input string name, input logic [63:0] exp, input int n);
        chk({name, "_count"}, ren_cols.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < ren_cols.size()) chk({name, "_col"}, ren_cols[i], {28'd0, exp[i*4 +: 4]});
        end
    endtask

    task automatic clear_log();
        ren_cols.delete();
        row_done_n   = 0;
        frame_done_n = 0;
        cfg_err_n    = 0;
    endtask

    task automatic set_cnt(input int k, input int v);
        i_element_count[k*CW +: CW] = CW'(v);
    endtask

    task automatic start_frame(input int size, input int rows);
        @(posedge i_clock); #1;
        i_start       = 1'b1;
        i_output_size = COLW'(size);
        i_output_rows = RW'(rows);
        @(posedge i_clock); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (frame_done_n == 0 && n < 300) begin
            @(posedge i_clock);
            n++;
        end
        #1;
        chk({name, "_frame_done"}, frame_done_n, 1);
    endtask

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge i_clock) begin
        int ok, e_ren, e_col, acc, e_rd, e_fd, e_cfg, good;
        cyc++;
        ok = 1;
        for (int k = 0; k < NF; k++) begin
            if (i_element_count[k*CW +: CW] < 3) ok = 0;
        end
        e_ren = (m_busy != 0 && m_issued < m_total && ok != 0 && (m_wv == 0 || i_pe_ready)) ? 1 : 0;
        e_col = m_issued % m_per_row;
        acc   = (m_wv != 0 && i_pe_ready) ? 1 : 0;
        e_rd  = (acc != 0 && (m_widx % m_per_row) == m_per_row - 1) ? 1 : 0;
        e_fd  = (acc != 0 && m_widx == m_total - 1) ? 1 : 0;
        good  = (i_output_size >= 3 && i_output_rows != 0) ? 1 : 0;
        e_cfg = (m_busy == 0 && i_start && good == 0) ? 1 : 0;
        if (cmp_en) begin
            chk("renable", o_renable, e_ren);
            chk("read_count", o_valid_read_count, e_col);
            chk("window_valid", o_window_valid, m_wv);
            chk("row_done", o_row_done, e_rd);
            chk("frame_done", o_frame_done, e_fd);
            chk("busy", o_busy, m_busy);
            chk("cfg_err", o_cfg_err, e_cfg);
            if (o_renable) begin
                if (ren_cols.size() == 0) first_ren = cyc;
                last_ren = cyc;
                ren_cols.push_back(int'(o_valid_read_count));
            end
            if (o_row_done)   row_done_n++;
            if (o_frame_done) frame_done_n++;
            if (o_cfg_err)    cfg_err_n++;
        end
        if (!i_reset) begin
            m_busy = 0; m_issued = 0; m_total = 0; m_per_row = 1; m_wv = 0; m_widx = 0;
        end else if (m_busy == 0) begin
            if (i_start && good != 0) begin
                m_busy    = 1;
                m_per_row = int'(i_output_size) - 1;
                m_total   = int'(i_output_rows) * m_per_row;
                m_issued  = 0;
                m_wv      = 0;
            end
        end else if (e_fd != 0) begin
            m_busy = 0;
            m_wv   = 0;
        end else if (e_ren != 0) begin
            m_widx = m_issued;
            m_issued++;
            m_wv = 1;
        end else if (acc != 0) begin
            m_wv = 0;
        end
    end

    initial begin
        logic [7:0] pat;
        pat = 8'b1011_0010;
        for (int k = 0; k < NF; k++) set_cnt(k, 16);
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        cmp_en  = 1'b1;
        @(negedge i_clock);
        chk("rst_busy", o_busy, 0);
        chk("rst_window_valid", o_window_valid, 0);
        chk("rst_renable", o_renable, 0);
        chk("rst_col", o_valid_read_count, 0);

        // Basic frame: size 5, 2 rows.
        clear_log();
        start_frame(5, 2);
        wait_frame("basic");
        chk_cols("basic", 64'h32103210, 8);
        chk("basic_row_done_n", row_done_n, 2);
        chk("basic_back_to_back", last_ren - first_ren, 7);
        @(negedge i_clock);
        chk("basic_idle_busy", o_busy, 0);

        // Backpressure mid-row.
        clear_log();
        start_frame(6, 1);
        @(posedge i_clock); #1;
        @(posedge i_clock); #1;
        i_pe_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge i_clock); #1; end
            @(negedge i_clock);
            chk("bp_renable", o_renable, 0);
            chk("bp_window_hold", o_window_valid, 1);
            chk("bp_col", o_valid_read_count, 2);
        end
        @(posedge i_clock); #1;
        i_pe_ready = 1'b1;
        @(negedge i_clock);
        chk("bp_resume", o_renable, 1);
        wait_frame("bp");
        chk_cols("bp", 64'h43210, 5);
        chk("bp_row_done_n", row_done_n, 1);

        // Starvation on FIFO 1.
        clear_log();
        start_frame(5, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clock); #1;
            set_cnt(1, 2);
            @(negedge i_clock);
            chk("starve_renable", o_renable, 0);
        end
        @(posedge i_clock); #1;
        set_cnt(1, 3);
        @(negedge i_clock);
        chk("starve_resume", o_renable, 1);
        @(posedge i_clock); #1;
        set_cnt(1, 16);
        wait_frame("starve");
        chk_cols("starve", 64'h3210, 4);

        // Bad configurations.
        @(posedge i_clock); #1;
        i_start = 1'b1; i_output_size = 6'd2; i_output_rows = 8'd4;
        @(negedge i_clock);
        chk("badcfg_size_err", o_cfg_err, 1);
        chk("badcfg_size_busy", o_busy, 0);
        @(posedge i_clock); #1;
        i_output_size = 6'd5; i_output_rows = 8'd0;
        @(negedge i_clock);
        chk("badcfg_rows_err", o_cfg_err, 1);
        @(posedge i_clock); #1;
        i_start = 1'b0;
        @(negedge i_clock);
        chk("badcfg_after_busy", o_busy, 0);
        chk("badcfg_after_err", o_cfg_err, 0);

        // Reset during row 1, then a fresh frame.
        clear_log();
        start_frame(5, 3);
        repeat (5) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        @(posedge i_clock); #1;
        i_reset = 1'b1;
        @(negedge i_clock);
        chk("rstmid_renable", o_renable, 0);
        chk("rstmid_window", o_window_valid, 0);
        chk("rstmid_busy", o_busy, 0);
        chk("rstmid_col", o_valid_read_count, 0);
        chk("rstmid_pulses", {o_row_done, o_frame_done, o_cfg_err}, 0);
        clear_log();
        start_frame(4, 2);
        wait_frame("rstmid");
        chk_cols("rstmid", 64'h210210, 6);

        // Start while busy is ignored.
        clear_log();
        start_frame(5, 1);
        @(posedge i_clock); #1;
        i_start = 1'b1; i_output_size = 6'd2; i_output_rows = 8'd3;
        @(negedge i_clock);
        chk("busy_start_no_err", o_cfg_err, 0);
        @(posedge i_clock); #1;
        i_output_size = 6'd3; i_output_rows = 8'd2;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        wait_frame("busystart");
        chk_cols("busystart", 64'h3210, 4);
        chk("busystart_cfg_err_n", cfg_err_n, 0);

        // Irregular ready pattern over a 3-row frame.
        clear_log();
        start_frame(4, 3);
        for (int i = 0; i < 100 && frame_done_n == 0; i++) begin
            @(posedge i_clock); #1;
            i_pe_ready = pat[i % 8];
        end
        i_pe_ready = 1'b1;
        chk("pattern_frame_done", frame_done_n, 1);
        chk_cols("pattern", 64'h210210210, 9);
        chk("pattern_row_done_n", row_done_n, 3);

        repeat (2) @(posedge i_clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
